// File: rtl/mult4x4_seq_ctrl_if.sv
// mult4x4_seq_ctrl_if: operand request, status and result bundle for the 4x4 sequential multiplier
interface mult4x4_seq_ctrl_if;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;
   modport master (output start, a, b, input busy, done, product);
   modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult4x4_seq_ctrl.sv
// mult4x4_seq_ctrl: 4x4 unsigned multiplier sequencing four 2x2 partial products
// through one shared multiplier_2bit cell, with shift-accumulate into an 8-bit result.
module multiplier_2bit (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] p
);
   logic t1, t2, t3, c;
   assign t1 = x[1] & y[0];
   assign t2 = x[0] & y[1];
   assign t3 = x[1] & y[1];
   assign c = t1 & t2;
   assign p = {t3 & c, t3 ^ c, t1 ^ t2, x[0] & y[0]};
endmodule

module mult4x4_seq_ctrl (
   input logic               clk,
   input logic               rst_n,
   mult4x4_seq_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0] state;
   logic [1:0] step;
   logic [3:0] a_q, b_q;
   logic [7:0] acc, product_q;
   logic [1:0] mx, my;
   logic [3:0] m;
   logic [2:0] sh;
   logic [7:0] pp, sum;
   // step[1] picks the high half of a, step[0] the high half of b
   always_comb begin
      mx = step[1] ? a_q[3:2] : a_q[1:0];
      my = step[0] ? b_q[3:2] : b_q[1:0];
      sh = (step == 2'd3) ? 3'd4 : (step == 2'd0) ? 3'd0 : 3'd2;
   end
   multiplier_2bit u_mul (.x(mx), .y(my), .p(m));
   assign pp = {4'd0, m} << sh;
   assign sum = acc + pp;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         step <= 2'd0;
         a_q <= 4'd0;
         b_q <= 4'd0;
         acc <= 8'd0;
         product_q <= 8'd0;
      end else
         case (state)
            IDLE, DONE:
               if (bus.start) begin
                  a_q <= bus.a;
                  b_q <= bus.b;
                  acc <= 8'd0;
                  step <= 2'd0;
                  state <= MUL;
               end else
                  state <= IDLE;
            MUL: begin
               acc <= sum;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  product_q <= sum;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
   assign bus.busy = state == MUL;
   assign bus.done = state == DONE;
   assign bus.product = product_q;
endmodule

// File: tb/tb_mult4x4_seq_ctrl.sv
// tb_mult4x4_seq_ctrl: randomized and directed checks of the 4x4 sequential multiplier
// against a plain a*b model with the five-cycle request-to-done timing.
module tb_mult4x4_seq_ctrl;
   logic clk, rst_n;
   int n_cmp, n_bad;
   logic [7:0] prev;
   mult4x4_seq_ctrl_if bus ();
   mult4x4_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
      chk({tag, "_done"}, {7'd0, bus.done}, 8'd0);
      chk({tag, "_prod"}, bus.product, prev);
   endtask
   // Caller sits at a negedge with start/a/b already driven for the accepting edge.
   task automatic op(input logic [3:0] x, input logic [3:0] y, input bit noise,
                     input bit chain, input logic [3:0] nx, input logic [3:0] ny);
      logic [7:0] exp;
      exp = 8'(x * y);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mul_busy", {7'd0, bus.busy}, 8'd1);
         chk("mul_done", {7'd0, bus.done}, 8'd0);
         chk("mul_hold", bus.product, prev);
         bus.start = noise ? 1'($urandom) : 1'b0;
         bus.a = noise ? 4'($urandom) : bus.a;
         bus.b = noise ? 4'($urandom) : bus.b;
      end
      @(negedge clk);
      chk("dn_done", {7'd0, bus.done}, 8'd1);
      chk("dn_busy", {7'd0, bus.busy}, 8'd0);
      chk("dn_prod", bus.product, exp);
      prev = exp;
      if (chain) begin
         bus.start = 1;
         bus.a = nx;
         bus.b = ny;
      end else begin
         bus.start = 0;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_chk("post");
         end
      end
   endtask
   task automatic go(input logic [3:0] x, input logic [3:0] y, input bit noise);
      bus.start = 1;
      bus.a = x;
      bus.b = y;
      op(x, y, noise, 0, 0, 0);
   endtask
   initial begin
      logic [3:0] x, y, nx, ny;
      n_cmp = 0;
      n_bad = 0;
      prev = 0;
      rst_n = 1;
      bus.start = 0;
      bus.a = 0;
      bus.b = 0;
      #3 rst_n = 0;
      repeat (3) @(negedge clk);
      idle_chk("rst");
      rst_n = 1;
      repeat (10) begin
         @(negedge clk);
         idle_chk("idle");
      end
      go(4'd2, 4'd3, 0);
      go(4'd15, 4'd15, 0);
      go(4'd0, 4'd9, 0);
      go(4'd15, 4'd1, 0);
      bus.start = 1;
      bus.a = 4'd7;
      bus.b = 4'd9;
      op(4'd7, 4'd9, 0, 1, 4'd12, 4'd5);
      op(4'd12, 4'd5, 0, 0, 0, 0);
      go(4'd3, 4'd3, 1);
      bus.start = 1;
      bus.a = 4'd13;
      bus.b = 4'd11;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      prev = 0;
      idle_chk("midrst");
      @(negedge clk);
      rst_n = 1;
      idle_chk("midrst_rel");
      go(4'd13, 4'd11, 0);
      repeat (40) begin
         x = 4'($urandom);
         y = 4'($urandom);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            idle_chk("gap");
         end
         go(x, y, 1'($urandom));
      end
      bus.start = 1;
      bus.a = 0;
      bus.b = 0;
      for (int i = 0; i < 256; i++) begin
         x = 4'(i >> 4);
         y = 4'(i);
         nx = 4'((i + 1) >> 4);
         ny = 4'(i + 1);
         op(x, y, 0, i != 255, nx, ny);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mult4x4_seq_ctrl.md
# mult4x4_seq_ctrl

Sequential 4x4-bit unsigned multiplier controller built around a single `multiplier_2bit` instance. It accepts an operand pair on a start strobe. It then time-multiplexes the 2-bit multiplier over the four 2-bit partial products (lo·lo, lo·hi, hi·lo, hi·hi), shift-accumulates them into an 8-bit product, and signals completion with a one-cycle `done` pulse. It is the FPGA top-level sequencer for the 4x4 multiplier and trades throughput for reuse of one 2x2 cell.

## Interface
- Parameters: none; operand width is fixed at 4 bits and product width at 8 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; released synchronously by the system.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  4  multiplicand; sampled on the accepting edge only.
- `b`  in  4  multiplier; sampled on the accepting edge only.
- `busy`  out  1  high while in MUL.
- `done`  out  1  one-cycle pulse; high in DONE.
- `product`  out  8  registered result `a*b` (unsigned); holds its value until the next completion.

## Operation
- Internal registers:
  - `a_q[3:0]` and `b_q[3:0]` hold the latched operands.
  - `acc[7:0]` is the accumulator.
  - `step[1:0]` is the step counter.
  - `state` is in {IDLE, MUL, DONE}.
  - `product_q[7:0]` holds the result.
- One `multiplier_2bit` instance. Its operand inputs are selected combinationally from `a_q`, `b_q` and `step`. Its 4-bit result is zero-extended and left-shifted into an 8-bit partial product.
- Step schedule:
  - step 0: `a_q[1:0]*b_q[1:0]`, shift 0
  - step 1: `a_q[1:0]*b_q[3:2]`, shift 2
  - step 2: `a_q[3:2]*b_q[1:0]`, shift 2
  - step 3: `a_q[3:2]*b_q[3:2]`, shift 4
- Accumulation is an 8-bit add. Overflow cannot occur, because the maximum sum is 225.
- State transitions:
  - IDLE: if `start`, latch `a`/`b` into `a_q`/`b_q`, clear `acc`, set `step` to 0 and go to MUL. Otherwise stay in IDLE.
  - MUL: on each edge, set `acc <= acc + pp(step)` and `step <= step + 1`.
    - At step 3, write `product_q <= acc + pp(3)` and go to DONE. `acc` also takes the final sum.
    - `start` is ignored in MUL, and `a`/`b` changes are ignored.
  - DONE: if `start`, accept new operands exactly as from IDLE and go to MUL (back-to-back). Otherwise go to IDLE.
- `busy` = (state == MUL); `done` = (state == DONE). Both are decoded from registered state only, so they are glitch-free.
- Unreachable state encodings recover to IDLE on the next edge.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `step` = 0, `acc` = 0, `a_q` = 0, `b_q` = 0, `product` = 0, `busy` = 0, `done` = 0. This takes effect immediately, including mid-operation. An in-flight computation is discarded and `product` returns to 0.
- Latency: with `start` accepted at edge k:
  - `busy` is high after edges k through k+3.
  - `product` is updated and `done` goes high after edge k+4.
  - `done` falls after edge k+5 unless the DONE-state start re-enters MUL, in which case `busy` rises in the same cycle.
- Throughput: one result per 5 cycles with continuous `start`; one per 6 cycles with an IDLE gap.
- `product` changes only on the transition MUL→DONE (and on reset). It is stable during MUL of the next operation.
- `start` held high continuously: accepted in IDLE and in every DONE cycle, ignored in MUL. No request is queued.
- Combinational path: from `a_q`/`b_q`/`step` through `multiplier_2bit` and the 8-bit adder to `acc`. The clock period must exceed the gate delays of `multiplier_2bit` (ns timescale) plus the adder delay.

## Test plan
- Reset then idle: hold `rst_n` low, then release with `start`=0 for 10 cycles. Required: `busy`=0, `done`=0, `product`=0 throughout.
- Single op: `a`=2, `b`=3, `start` pulsed 1 cycle at edge k. Required: `busy` high for 4 cycles; `done`=1 for exactly 1 cycle after edge k+4; `product`=6 from then until the next completion.
- Extremes and exhaustive: 15×15 must give 225, 0×9 must give 0, and 15×1 must give 15. Then sweep all 256 (`a`,`b`) pairs and compare each result to `a*b`.
- Back-to-back: hold `start`=1 with `a`=7, `b`=9, then change to `a`=12, `b`=5 during the first DONE cycle. Required: `done` pulses spaced 5 cycles apart, and `product` is 63 then 60.
- Ignored start and operand change: assert `start` with `a`=3, `b`=3. During MUL, pulse `start` and change `a`=15. Required: the result is 9, exactly one `done` pulse, and no extra operation.
- Reset mid-op: start 13×11, and assert `rst_n`=0 after 2 MUL cycles. Required: immediately `busy`=0, `done`=0, `product`=0. After release, a new 13×11 produces 143.
